// File: rtl/atm_pkg.sv
// Shared types for the ATM account arbiter: op codes, FSM states,
// default balance width.
package atm_pkg;

  localparam int DEF_BALANCE_WIDTH = 20;

  typedef enum logic [1:0] {
    OP_WITHDRAW = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_INQUIRY  = 2'b10,
    OP_ILLEGAL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_EXEC,
    S_WR,
    S_RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after
// the pointer, wrapping around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx
);

  logic found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter sequencing atomic read-modify-write
// transactions from N_REQ ATM terminals onto one balance RAM.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int BALANCE_WIDTH = DEF_BALANCE_WIDTH,
  parameter int ACCT_WIDTH    = 8,
  parameter int RD_LATENCY    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req,
  input  logic [2*N_REQ-1:0]               req_op,
  input  logic [ACCT_WIDTH*N_REQ-1:0]      req_acct,
  input  logic [BALANCE_WIDTH*N_REQ-1:0]   req_value,
  output logic [N_REQ-1:0]                 gnt,
  output logic [N_REQ-1:0]                 done,
  output logic [BALANCE_WIDTH-1:0]         rsp_balance,
  output logic                             rsp_error,
  output logic                             mem_rd_en,
  output logic                             mem_wr_en,
  output logic [ACCT_WIDTH-1:0]            mem_addr,
  output logic [BALANCE_WIDTH-1:0]         mem_wdata,
  input  logic [BALANCE_WIDTH-1:0]         mem_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e                   state, state_n;
  logic [IW-1:0]            ptr, idx;
  logic [1:0]               op;
  logic [ACCT_WIDTH-1:0]    acct;
  logic [BALANCE_WIDTH-1:0] value, bal, new_bal;
  logic                     err;
  logic [CW-1:0]            wait_cnt;

  logic [N_REQ-1:0]         win;
  logic [IW-1:0]            win_idx;
  logic [BALANCE_WIDTH:0]   sum;
  logic [BALANCE_WIDTH-1:0] alu_bal;
  logic                     alu_err, alu_wr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= IW'(N_REQ - 1);
      idx      <= '0;
      gnt      <= '0;
      op       <= '0;
      acct     <= '0;
      value    <= '0;
      bal      <= '0;
      new_bal  <= '0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: if (|req) begin
          idx      <= win_idx;
          gnt      <= win;
          op       <= req_op[2*int'(win_idx) +: 2];
          acct     <= req_acct[ACCT_WIDTH*int'(win_idx) +: ACCT_WIDTH];
          value    <= req_value[BALANCE_WIDTH*int'(win_idx) +: BALANCE_WIDTH];
          wait_cnt <= CW'(RD_LATENCY - 1);
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == '0) bal <= mem_rdata;
        end
        S_EXEC: begin
          new_bal <= alu_bal;
          err     <= alu_err;
        end
        S_RESP: begin
          ptr <= idx;
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Extra carry bit exposes deposit overflow.
  assign sum = {1'b0, bal} + {1'b0, value};

  always_comb begin
    alu_bal = bal;
    alu_err = 1'b0;
    alu_wr  = 1'b0;
    unique case (op)
      OP_WITHDRAW: begin
        if (value > bal) alu_err = 1'b1;
        else begin
          alu_bal = bal - value;
          alu_wr  = 1'b1;
        end
      end
      OP_DEPOSIT: begin
        if (sum[BALANCE_WIDTH]) alu_err = 1'b1;
        else begin
          alu_bal = sum[BALANCE_WIDTH-1:0];
          alu_wr  = 1'b1;
        end
      end
      OP_INQUIRY: ;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_n     = state;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    done        = '0;
    rsp_balance = '0;
    rsp_error   = 1'b0;
    unique case (state)
      S_IDLE: if (|req) state_n = S_RD;
      S_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = acct;
        state_n   = S_WAIT;
      end
      S_WAIT: if (wait_cnt == '0) state_n = S_EXEC;
      S_EXEC: state_n = alu_wr ? S_WR : S_RESP;
      S_WR: begin
        mem_wr_en = 1'b1;
        mem_addr  = acct;
        mem_wdata = new_bal;
        state_n   = S_RESP;
      end
      S_RESP: begin
        done        = gnt;
        rsp_balance = new_bal;
        rsp_error   = err;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter with RAM models for
// read latencies 1 and 3.
module tb_atm_account_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req3;
  logic [7:0]  req_op;
  logic [31:0] req_acct;
  logic [79:0] req_value;

  logic [3:0]  gnt, done, gnt3, done3;
  logic [19:0] rsp_balance, rsp_balance3;
  logic        rsp_error, rsp_error3;
  logic        mem_rd_en, mem_wr_en, rd3, wr3;
  logic [7:0]  mem_addr, addr3;
  logic [19:0] mem_wdata, wdata3, mem_rdata, rdata3;

  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [19:0] pre_data;

  logic [19:0] mem  [0:255];
  logic [19:0] mem3 [0:255];
  logic [19:0] p1, p2;

  int cyc = 0;
  int wr_cnt = 0, wr_cyc = 0, wr3_cnt = 0, wr3_cyc = 0;
  int both_cnt = 0;
  logic [7:0]  wr_addr;
  logic [19:0] wr_data;
  int done_log [0:31];
  int done_n = 0;

  int n_vec = 0, n_bad = 0;
  int got_lat;
  logic [19:0] got_bal;
  logic        got_err;

  always #5 clk = ~clk;

  atm_account_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op),
    .req_acct(req_acct), .req_value(req_value),
    .gnt(gnt), .done(done), .rsp_balance(rsp_balance),
    .rsp_error(rsp_error), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  atm_account_arbiter #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_op(req_op),
    .req_acct(req_acct), .req_value(req_value),
    .gnt(gnt3), .done(done3), .rsp_balance(rsp_balance3),
    .rsp_error(rsp_error3), .mem_rd_en(rd3),
    .mem_wr_en(wr3), .mem_addr(addr3),
    .mem_wdata(wdata3), .mem_rdata(rdata3)
  );

  function automatic int oh(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) begin
      mem[pre_addr]  <= pre_data;
      mem3[pre_addr] <= pre_data;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      if (wr3) mem3[addr3] <= wdata3;
    end
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (rd3) p1 <= mem3[addr3];
    p2     <= p1;
    rdata3 <= p2;
    if (mem_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_cyc  <= cyc;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    if (wr3) begin
      wr3_cnt <= wr3_cnt + 1;
      wr3_cyc <= cyc;
    end
    if ((mem_rd_en && mem_wr_en) || (rd3 && wr3)) both_cnt <= both_cnt + 1;
    if (|done && done_n < 32) begin
      done_log[done_n] <= oh(done);
      done_n <= done_n + 1;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(logic [7:0] a, logic [19:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; req3 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_fields(int t, logic [1:0] o, logic [7:0] a, logic [19:0] v);
    req_op[t*2 +: 2]     = o;
    req_acct[t*8 +: 8]   = a;
    req_value[t*20 +: 20] = v;
  endtask

  // Returns latency from sampling edge to done, or -1 on timeout.
  task automatic txn(int t, logic [1:0] o, logic [7:0] a, logic [19:0] v, output int t0);
    int n;
    @(negedge clk);
    set_fields(t, o, a, v);
    req[t] = 1'b1;
    t0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[t] && n < 20);
    got_lat = done[t] ? cyc - t0 : -1;
    got_bal = rsp_balance;
    got_err = rsp_error;
    req[t] = 1'b0;
  endtask

  initial begin
    int t0, wb, base, n;
    rst = 1'b1; req = '0; req3 = '0;
    req_op = '0; req_acct = '0; req_value = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_strobes", {30'b0, mem_rd_en, mem_wr_en}, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    rst = 1'b0;

    preload(8'd5, 20'd1000);
    wb = wr_cnt;
    txn(0, 2'b00, 8'd5, 20'd300, t0);
    chk("wd_lat", got_lat, 5);
    chk("wd_bal", 32'(got_bal), 700);
    chk("wd_err", 32'(got_err), 0);
    chk("wd_wrcnt", wr_cnt - wb, 1);
    chk("wd_wrlat", wr_cyc - t0, 4);
    chk("wd_wraddr", 32'(wr_addr), 5);
    chk("wd_wrdata", 32'(wr_data), 700);
    chk("wd_mem", 32'(mem[5]), 700);

    preload(8'd7, 20'd100);
    wb = wr_cnt;
    txn(1, 2'b00, 8'd7, 20'd101, t0);
    chk("od_lat", got_lat, 4);
    chk("od_err", 32'(got_err), 1);
    chk("od_bal", 32'(got_bal), 100);
    chk("od_nowr", wr_cnt - wb, 0);

    preload(8'd9, 20'hFFFFF);
    wb = wr_cnt;
    txn(2, 2'b01, 8'd9, 20'd1, t0);
    chk("ov_err", 32'(got_err), 1);
    chk("ov_bal", 32'(got_bal), 32'hFFFFF);
    chk("ov_nowr", wr_cnt - wb, 0);
    txn(3, 2'b01, 8'd9, 20'd0, t0);
    chk("d0_err", 32'(got_err), 0);
    chk("d0_bal", 32'(got_bal), 32'hFFFFF);
    chk("d0_wr", wr_cnt - wb, 1);
    chk("d0_wrdata", 32'(wr_data), 32'hFFFFF);

    wb = wr_cnt;
    txn(1, 2'b10, 8'd7, 20'd55, t0);
    chk("inq_bal", 32'(got_bal), 100);
    chk("inq_err", 32'(got_err), 0);
    chk("inq_lat", got_lat, 4);
    txn(2, 2'b11, 8'd7, 20'd5, t0);
    chk("ill_err", 32'(got_err), 1);
    chk("ill_bal", 32'(got_bal), 100);
    chk("inq_ill_nowr", wr_cnt - wb, 0);

    txn(0, 2'b00, 8'd5, 20'd700, t0);
    chk("ex_bal", 32'(got_bal), 0);
    chk("ex_err", 32'(got_err), 0);
    chk("ex_mem", 32'(mem[5]), 0);

    do_reset();
    for (int i = 0; i < 4; i++) set_fields(i, 2'b10, 8'(10 + i), 20'd0);
    base = done_n;
    req = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_n < base + 5 && n < 60);
    req = '0;
    chk("rr_cnt", done_n - base, 5);
    chk("rr_0", done_log[base], 0);
    chk("rr_1", done_log[base + 1], 1);
    chk("rr_2", done_log[base + 2], 2);
    chk("rr_3", done_log[base + 3], 3);
    chk("rr_4", done_log[base + 4], 0);

    do_reset();
    preload(8'd3, 20'd0);
    wb = wr_cnt;
    @(negedge clk);
    set_fields(0, 2'b01, 8'd3, 20'd50);
    set_fields(1, 2'b01, 8'd3, 20'd50);
    req = 4'b0011;
    n = 0;
    while (req[1:0] != 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
      if (done[0]) req[0] = 1'b0;
      if (done[1]) req[1] = 1'b0;
    end
    req = '0;
    chk("atom_mem", 32'(mem[3]), 100);
    chk("atom_wr", wr_cnt - wb, 2);

    preload(8'd5, 20'd700);
    wb = wr_cnt;
    @(negedge clk);
    set_fields(2, 2'b00, 8'd5, 20'd100);
    req[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("rw_gnt", 32'(gnt), 0);
    chk("rw_done", 32'(done), 0);
    chk("rw_wren", 32'(mem_wr_en), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rw_nowr", wr_cnt - wb, 0);
    chk("rw_mem", 32'(mem[5]), 700);

    preload(8'd5, 20'd1000);
    wb = wr3_cnt;
    @(negedge clk);
    set_fields(0, 2'b00, 8'd5, 20'd300);
    req3[0] = 1'b1;
    t0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done3[0] && n < 20);
    got_lat = done3[0] ? cyc - t0 : -1;
    got_bal = rsp_balance3;
    got_err = rsp_error3;
    req3 = '0;
    chk("l3_lat", got_lat, 7);
    chk("l3_bal", 32'(got_bal), 700);
    chk("l3_err", 32'(got_err), 0);
    chk("l3_wrlat", wr3_cyc - t0, 6);
    chk("l3_wr", wr3_cnt - wb, 1);
    chk("l3_mem", 32'(mem3[5]), 700);

    repeat (2) @(negedge clk);
    chk("rd_wr_excl", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
